aurora_tx_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single Aurora 64B/66B TX AXI4-Stream channel among several user-clock-domain requesters, e.g. the NoC CDC FIFO and a local control/status source. It sits between the requesters' stream outputs and the Aurora core `s_axi_tx_*` port. It holds a grant for a whole packet, so beats from different requesters never interleave on the link. It gates traffic on `channel_up` and flushes a packet that is cut off by link loss.

---
 rtl/aurora_pkg.sv | 20 ++
 rtl/rr_pick.sv | 37 +++
 rtl/aurora_tx_arb.sv | 147 ++++++++++++++
 tb/tb_aurora_tx_arb.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora TX-side blocks.
// Contents:
//   AURORA_DATA_W : Aurora 64B/66B lane width in bits
//   arb_state_t   : TX arbiter state encoding (idle / send / drop)
//   idx_w()       : width of an index into n items (minimum 1 bit)
package aurora_pkg;

  localparam int unsigned AURORA_DATA_W = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDrop = 2'd2
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Picks the lowest requester index at or above ptr, wrapping modulo N.
// Ports:
//   req     in  N : request vector
//   ptr     in  W : round-robin start index (must be < N)
//   gnt_idx out W : winning index (0 when no request)
//   any     out 1 : at least one request is set
module rr_pick
  import aurora_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int         idx;
  logic [W-1:0] sel;

  always_comb begin
    gnt_idx = '0;
    any     = |req;
    idx     = 0;
    sel     = '0;
    // Scan from the farthest offset down so the nearest one to ptr wins last.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(N)) idx = idx - int'(N);
      sel = W'(idx);
      if (req[sel]) gnt_idx = sel;
    end
  end

endmodule

// File: rtl/aurora_tx_arb.sv
// Packet-granular round-robin arbiter in front of the Aurora 64B/66B TX
// AXI4-Stream port. A grant is held for a whole packet; traffic is gated on
// channel_up and a packet cut off by link loss or the length cap is flushed.
// Optional build macro: AURORA_TX_ARB_PRIO0_EN gives requester 0 strict
// priority at arbitration time (grants stay non-preemptive).
// Ports:
//   clk, rst_n   : Aurora user_clk, async active-low reset
//   channel_up   : link status
//   req_valid/req_ready/req_data/req_last : NUM_REQ requester streams
//   tx_tdata/tx_tvalid/tx_tready          : to/from Aurora s_axi_tx_*
//   grant_id     : current or last granted requester
//   busy         : high in SEND or DROP
//   trunc_err    : one-cycle pulse on a forced release
module aurora_tx_arb
  import aurora_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = AURORA_DATA_W,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      channel_up,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [DATA_W-1:0]         tx_tdata,
  output logic                      tx_tvalid,
  input  logic                      tx_tready,
  output logic [idx_w(NUM_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      trunc_err
);

  localparam int unsigned GW = idx_w(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CntCapLast = CW'(MAX_BEATS - 1);
  localparam logic [CW-1:0] CntFull    = CW'(MAX_BEATS);
  localparam logic [GW-1:0] LastIdx    = GW'(NUM_REQ - 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [GW-1:0]     pick_idx;
  logic              pick_any;
  logic [GW-1:0]     win_idx;
  logic [GW-1:0]     next_ptr;
  logic [GW-1:0]     adv_ptr;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

  assign g_valid  = req_valid[grant_q];
  assign g_last   = req_last[grant_q];
  assign g_data   = req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign next_ptr = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

`ifdef AURORA_TX_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation and never moves the pointer.
  assign win_idx = req_valid[0] ? '0 : pick_idx;
  assign adv_ptr = (grant_q == '0) ? rr_ptr_q : next_ptr;
`else
  assign win_idx = pick_idx;
  assign adv_ptr = next_ptr;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    tx_tvalid  = 1'b0;
    tx_tdata   = '0;
    trunc_err  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (channel_up && pick_any) begin
          grant_d    = win_idx;
          beat_cnt_d = '0;
          state_d    = StSend;
        end
      end

      StSend: begin
        tx_tdata = g_data;
        if (!channel_up) begin
          // Hold the requester off this cycle; DROP consumes the rest.
          trunc_err = 1'b1;
          state_d   = StDrop;
        end else begin
          tx_tvalid          = g_valid;
          req_ready[grant_q] = tx_tready;
          if (g_valid && tx_tready) begin
            if (beat_cnt_q != CntFull) beat_cnt_d = beat_cnt_q + 1'b1;
            if (g_last) begin
              rr_ptr_d = adv_ptr;
              state_d  = StIdle;
            end else if (beat_cnt_q == CntCapLast) begin
              trunc_err = 1'b1;
              rr_ptr_d  = adv_ptr;
              state_d   = StDrop;
            end
          end
        end
      end

      StDrop: begin
        req_ready[grant_q] = 1'b1;
        if (g_valid && g_last) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_aurora_tx_arb.sv
// Directed self-checking bench for aurora_tx_arb (NUM_REQ=4, MAX_BEATS=4).
module tb_aurora_tx_arb;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             channel_up = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [DW-1:0]    tx_tdata;
  logic             tx_tvalid;
  logic             tx_tready = 1'b0;
  logic [1:0]       grant_id;
  logic             busy;
  logic             trunc_err;

  aurora_tx_arb #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .MAX_BEATS(MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .channel_up(channel_up),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Requester source model: packets of plen beats, total beats overall.
  int plen[NR];
  int total[NR];
  int sent[NR];

  // Link monitor.
  logic [DW-1:0] tx_q[$];
  int            gid_q[$];
  int            cyc_q[$];
  int            cyc;
  int            trunc_cnt;
  int            stall_cnt;
  int            stall_err;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  function automatic logic [DW-1:0] mkdata(input int r, input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 32) | 64'(k);
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (sent[i] < total[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = ((sent[i] % plen[i]) == plen[i] - 1);
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
      req_data[i*DW +: DW] = mkdata(i, sent[i]);
    end
  endtask

  task automatic set_src(input int r, input int pl, input int tot);
    plen[r]  = pl;
    total[r] = tot;
    sent[r]  = 0;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    gid_q.delete();
    cyc_q.delete();
    trunc_cnt  = 0;
    stall_cnt  = 0;
    stall_err  = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
  endtask

  // One clock: observe at negedge, advance sources just after posedge.
  task automatic cycle();
    logic [NR-1:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready;
    if (tx_tvalid && tx_tready) begin
      tx_q.push_back(tx_tdata);
      gid_q.push_back(int'(grant_id));
      cyc_q.push_back(cyc);
    end
    if (tx_tvalid && prev_stall && (tx_tdata !== prev_data)) stall_err++;
    prev_stall = tx_tvalid && !tx_tready;
    if (prev_stall) begin
      stall_cnt++;
      prev_data = tx_tdata;
    end
    if (trunc_err) trunc_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (fire[i]) sent[i]++;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) set_src(i, 1, 0);
    channel_up = 1'b1;
    tx_tready  = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) set_src(i, 1, 0);
    set_src(1, 2, 2);
    channel_up = 1'b1;
    tx_tready  = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (tx_tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_tvalid got=%b want=0", tx_tvalid);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    n_cmp++;
    if (trunc_err !== 1'b0) begin
      n_err++; $display("FAIL reset_trunc got=%b want=0", trunc_err);
    end
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_err++; $display("FAIL reset_grant got=%0d want=0", grant_id);
    end
    n_cmp++;
    if (tx_tdata !== '0) begin
      n_err++; $display("FAIL reset_tdata got=%h want=0", tx_tdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int guard;
    do_reset();
    set_src(1, 3, 3);
    set_src(3, 3, 3);
    drive();
    guard = 0;
    while ((sent[1] < 3 || sent[3] < 3) && guard < 50) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (guard >= 50) begin
      n_err++; $display("FAIL rr_timeout sent1=%0d sent3=%0d want=3/3", sent[1], sent[3]);
    end
    n_cmp++;
    if (tx_q.size() != 6) begin
      n_err++; $display("FAIL rr_count got=%0d want=6", tx_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k < tx_q.size()) begin
        n_cmp++;
        if (tx_q[k] !== mkdata(k < 3 ? 1 : 3, k % 3) || gid_q[k] != (k < 3 ? 1 : 3)) begin
          n_err++;
          $display("FAIL rr_beat%0d got=%h/g%0d want=%h/g%0d", k, tx_q[k], gid_q[k],
                   mkdata(k < 3 ? 1 : 3, k % 3), k < 3 ? 1 : 3);
        end
      end
    end
    if (cyc_q.size() >= 4) begin
      n_cmp++;
      if ((cyc_q[1] - cyc_q[0]) != 1 || (cyc_q[3] - cyc_q[2]) != 2) begin
        n_err++;
        $display("FAIL rr_spacing got=%0d,%0d want=1,2", cyc_q[1] - cyc_q[0],
                 cyc_q[3] - cyc_q[2]);
      end
    end
    // Pointer must have wrapped to 0: requester 0 beats requester 2.
    clear_mon();
    set_src(0, 1, 1);
    set_src(2, 1, 1);
    drive();
    guard = 0;
    while ((sent[0] < 1 || sent[2] < 1) && guard < 30) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (gid_q.size() != 2 || gid_q[0] != 0 || gid_q[1] != 2) begin
      n_err++;
      $display("FAIL rr_ptr_wrap got_n=%0d first=%0d want=2 beats g0 then g2", gid_q.size(),
               gid_q.size() > 0 ? gid_q[0] : -1);
    end
  endtask

  task automatic test_stall();
    int guard;
    int ph;
    do_reset();
    set_src(2, 4, 4);
    drive();
    guard = 0;
    ph    = 0;
    while (sent[2] < 4 && guard < 40) begin
      if (busy) begin
        tx_tready = (ph % 2 == 0);
        ph++;
      end else begin
        tx_tready = 1'b1;
      end
      cycle();
      guard++;
    end
    tx_tready = 1'b1;
    n_cmp++;
    if (guard >= 40) begin
      n_err++; $display("FAIL stall_timeout sent=%0d want=4", sent[2]);
    end
    n_cmp++;
    if (tx_q.size() != 4) begin
      n_err++; $display("FAIL stall_count got=%0d want=4", tx_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < tx_q.size()) begin
        n_cmp++;
        if (tx_q[k] !== mkdata(2, k) || gid_q[k] != 2) begin
          n_err++;
          $display("FAIL stall_beat%0d got=%h/g%0d want=%h/g2", k, tx_q[k], gid_q[k],
                   mkdata(2, k));
        end
      end
    end
    n_cmp++;
    if (stall_cnt != 3) begin
      n_err++; $display("FAIL stall_cycles got=%0d want=3", stall_cnt);
    end
    n_cmp++;
    if (stall_err != 0) begin
      n_err++; $display("FAIL stall_stable got=%0d changes want=0", stall_err);
    end
  endtask

  task automatic test_link_loss();
    int guard;
    do_reset();
    set_src(1, 5, 5);
    drive();
    guard = 0;
    while (tx_q.size() < 2 && guard < 30) begin
      cycle();
      guard++;
    end
    channel_up = 1'b0;
    drive();
    #1;
    n_cmp++;
    if (tx_tvalid !== 1'b0 || trunc_err !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL loss_edge got tvalid=%b trunc=%b busy=%b want=0/1/1", tx_tvalid,
               trunc_err, busy);
    end
    guard = 0;
    while (sent[1] < 5 && guard < 30) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (sent[1] != 5 || tx_q.size() != 2) begin
      n_err++;
      $display("FAIL loss_flush got consumed=%0d sent_on_link=%0d want=5/2", sent[1],
               tx_q.size());
    end
    n_cmp++;
    if (trunc_cnt != 1) begin
      n_err++; $display("FAIL loss_trunc_pulses got=%0d want=1", trunc_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL loss_idle got busy=%b want=0", busy);
    end
    set_src(2, 1, 1);
    drive();
    repeat (5) cycle();
    n_cmp++;
    if (sent[2] != 0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL loss_gated got sent=%0d busy=%b ready=%b want=0/0/0000", sent[2], busy,
               req_ready);
    end
    channel_up = 1'b1;
    drive();
    guard = 0;
    while (sent[2] < 1 && guard < 20) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (tx_q.size() != 3 || tx_q[tx_q.size()-1] !== mkdata(2, 0)) begin
      n_err++; $display("FAIL loss_resume got beats=%0d want=3 ending with req2 beat0",
                        tx_q.size());
    end
  endtask

  task automatic test_cap();
    int guard;
    logic [DW-1:0] exp_d5;
    int exp_g5;
`ifdef AURORA_TX_ARB_PRIO0_EN
    exp_d5 = mkdata(0, 6);
    exp_g5 = 0;
`else
    exp_d5 = mkdata(1, 0);
    exp_g5 = 1;
`endif
    do_reset();
    set_src(0, 6, 12);
    set_src(1, 1, 1);
    drive();
    guard = 0;
    while (tx_q.size() < 5 && guard < 60) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (guard >= 60) begin
      n_err++; $display("FAIL cap_timeout got beats=%0d want=5", tx_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < tx_q.size()) begin
        n_cmp++;
        if (tx_q[k] !== mkdata(0, k) || gid_q[k] != 0) begin
          n_err++;
          $display("FAIL cap_beat%0d got=%h/g%0d want=%h/g0", k, tx_q[k], gid_q[k],
                   mkdata(0, k));
        end
      end
    end
    if (tx_q.size() >= 5) begin
      n_cmp++;
      if (tx_q[4] !== exp_d5 || gid_q[4] != exp_g5) begin
        n_err++;
        $display("FAIL cap_next got=%h/g%0d want=%h/g%0d", tx_q[4], gid_q[4], exp_d5, exp_g5);
      end
    end
    n_cmp++;
    if (trunc_cnt != 1) begin
      n_err++; $display("FAIL cap_trunc_pulses got=%0d want=1", trunc_cnt);
    end
    n_cmp++;
    if (sent[0] < 6) begin
      n_err++; $display("FAIL cap_dropped got consumed=%0d want>=6", sent[0]);
    end
  endtask

  task automatic test_rotate();
    int guard;
    int exp_g[5];
    logic [DW-1:0] exp_d[5];
`ifdef AURORA_TX_ARB_PRIO0_EN
    exp_g = '{0, 0, 0, 1, 2};
    for (int k = 0; k < 3; k++) exp_d[k] = mkdata(0, k);
    exp_d[3] = mkdata(1, 0);
    exp_d[4] = mkdata(2, 0);
`else
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) exp_d[k] = mkdata(k % 4, k / 4);
`endif
    do_reset();
    for (int i = 0; i < NR; i++) set_src(i, 1, 3);
    drive();
    guard = 0;
    while (tx_q.size() < 5 && guard < 40) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (tx_q.size() < 5) begin
      n_err++; $display("FAIL rot_timeout got beats=%0d want=5", tx_q.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < tx_q.size()) begin
        n_cmp++;
        if (gid_q[k] != exp_g[k] || tx_q[k] !== exp_d[k]) begin
          n_err++;
          $display("FAIL rot_grant%0d got=g%0d/%h want=g%0d/%h", k, gid_q[k], tx_q[k],
                   exp_g[k], exp_d[k]);
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc_q[k] - cyc_q[k-1] != 2) begin
            n_err++;
            $display("FAIL rot_spacing%0d got=%0d want=2", k, cyc_q[k] - cyc_q[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    set_src(2, 1, 1);
    drive();
    guard = 0;
    while (sent[2] < 1 && guard < 20) begin
      cycle();
      guard++;
    end
    set_src(3, 5, 5);
    drive();
    guard = 0;
    while (tx_q.size() < 3 && guard < 20) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd3) begin
      n_err++; $display("FAIL arst_pre got busy=%b grant=%0d want=1/3", busy, grant_id);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_tvalid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000 ||
        tx_tdata !== '0 || trunc_err !== 1'b0) begin
      n_err++;
      $display("FAIL arst_outputs got tvalid=%b busy=%b grant=%0d ready=%b tdata=%h trunc=%b",
               tx_tvalid, busy, grant_id, req_ready, tx_tdata, trunc_err);
    end
    for (int i = 0; i < NR; i++) set_src(i, 1, 0);
    set_src(1, 1, 1);
    set_src(3, 1, 1);
    drive();
    clear_mon();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    guard = 0;
    while (tx_q.size() < 1 && guard < 20) begin
      cycle();
      guard++;
    end
    n_cmp++;
    if (tx_q.size() < 1 || gid_q[0] != 1 || tx_q[0] !== mkdata(1, 0)) begin
      n_err++;
      $display("FAIL arst_first_grant got beats=%0d grant=%0d want=1 beat from req1",
               tx_q.size(), gid_q.size() > 0 ? gid_q[0] : -1);
    end
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < NR; i++) set_src(i, 1, 0);
    clear_mon();
    test_reset();
    test_round_robin();
    test_stall();
    test_link_loss();
    test_cap();
    test_rotate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
